// File: rtl/byte_bit_sequencer.sv
// Byte-to-bit sequencer: accepts a byte over valid/ready, then walks bit_n across
// all eight positions, holding each for BIT_CYCLES clocks.
module byte_bit_sequencer #(
   parameter int unsigned BIT_CYCLES = 4,
   parameter int unsigned MSB_FIRST  = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic [7:0] hold_byte,
   output logic [2:0] bit_n,
   output logic       bit_strobe,
   output logic       busy,
   output logic       frame_done
);

   localparam int unsigned   CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [2:0]    FIRST_BIT = (MSB_FIRST != 0) ? 3'd7 : 3'd0;

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [CW-1:0] cyc_cnt;
   logic [2:0]    bit_cnt;
   logic          bit_end;
   logic          frame_end;
   logic          accept;

   always_comb begin
      bit_end    = (state == SEND) && (cyc_cnt == CYC_LAST);
      frame_end  = bit_end && (bit_cnt == 3'd7);
      data_ready = rst_n && ((state == IDLE) || frame_end);
      accept     = data_valid && data_ready;
   end

   // Accept takes priority over frame end so back-to-back bytes reload with no gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cyc_cnt    <= '0;
         bit_cnt    <= '0;
         hold_byte  <= '0;
         bit_n      <= '0;
         bit_strobe <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         bit_strobe <= 1'b0;
         frame_done <= frame_end;
         if (accept) begin
            state      <= SEND;
            busy       <= 1'b1;
            hold_byte  <= data_in;
            bit_n      <= FIRST_BIT;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            bit_strobe <= 1'b1;
         end else if (frame_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
         end else if (bit_end) begin
            cyc_cnt    <= '0;
            bit_cnt    <= bit_cnt + 3'd1;
            bit_n      <= (MSB_FIRST != 0) ? bit_n - 3'd1 : bit_n + 3'd1;
            bit_strobe <= 1'b1;
         end else if (state == SEND) begin
            cyc_cnt <= cyc_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_byte_bit_sequencer.sv
// Bench for byte_bit_sequencer: four parameterisations share the stimulus; a
// time-since-accept model checks every cycle, directed literals pin the model.
module tb_byte_bit_sequencer;

   localparam int NI = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] data_in = 8'hFF;
   logic data_valid = 1'b1;

   logic [NI-1:0]      ready_w;
   logic [NI-1:0][7:0] hold_w;
   logic [NI-1:0][2:0] bitn_w;
   logic [NI-1:0]      strobe_w;
   logic [NI-1:0]      busy_w;
   logic [NI-1:0]      fd_w;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   byte_bit_sequencer #(.BIT_CYCLES(4), .MSB_FIRST(0)) u0 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(ready_w[0]), .hold_byte(hold_w[0]), .bit_n(bitn_w[0]),
      .bit_strobe(strobe_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
   byte_bit_sequencer #(.BIT_CYCLES(4), .MSB_FIRST(1)) u1 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(ready_w[1]), .hold_byte(hold_w[1]), .bit_n(bitn_w[1]),
      .bit_strobe(strobe_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
   byte_bit_sequencer #(.BIT_CYCLES(2), .MSB_FIRST(0)) u2 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(ready_w[2]), .hold_byte(hold_w[2]), .bit_n(bitn_w[2]),
      .bit_strobe(strobe_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));
   byte_bit_sequencer #(.BIT_CYCLES(1), .MSB_FIRST(0)) u3 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(ready_w[3]), .hold_byte(hold_w[3]), .bit_n(bitn_w[3]),
      .bit_strobe(strobe_w[3]), .busy(busy_w[3]), .frame_done(fd_w[3]));

   function automatic int bc_of(input int i);
      case (i)
         0, 1:    return 4;
         2:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic int idx(input int i, input int k);
      return (i == 1) ? 7 - k : k;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Model: t = clocks since the last accept (-1 = nothing since reset).
   int       t[NI]     = '{-1, -1, -1, -1};
   bit [7:0] mhold[NI] = '{8'h00, 8'h00, 8'h00, 8'h00};
   bit       mfd[NI]   = '{1'b0, 1'b0, 1'b0, 1'b0};

   always @(posedge clk) begin
      int fl;
      bit rdy;
      for (int i = 0; i < NI; i++) begin
         fl  = 8 * bc_of(i);
         rdy = rst_n && !(t[i] >= 0 && t[i] < fl - 1);
         if (!rst_n) begin
            t[i]     = -1;
            mhold[i] = 8'h00;
            mfd[i]   = 1'b0;
         end else begin
            mfd[i] = (t[i] == fl - 1);
            if (data_valid && rdy) begin
               t[i]     = 0;
               mhold[i] = data_in;
            end else if (t[i] >= 0 && t[i] < fl) begin
               t[i]++;
            end
         end
      end
   end

   initial begin : compare
      int fl, bc, ebn;
      bit ebusy;
      forever begin
         @(posedge clk);
         #3;
         for (int i = 0; i < NI; i++) begin
            bc    = bc_of(i);
            fl    = 8 * bc;
            ebusy = (t[i] >= 0 && t[i] < fl);
            ebn   = ebusy ? idx(i, t[i] / bc) : ((t[i] < 0) ? 0 : idx(i, 7));
            chk($sformatf("u%0d.busy", i), int'(busy_w[i]), int'(ebusy));
            chk($sformatf("u%0d.bit_n", i), int'(bitn_w[i]), ebn);
            chk($sformatf("u%0d.bit_strobe", i), int'(strobe_w[i]),
                int'(ebusy && (t[i] % bc == 0)));
            chk($sformatf("u%0d.frame_done", i), int'(fd_w[i]), int'(mfd[i]));
            chk($sformatf("u%0d.hold_byte", i), int'(hold_w[i]), int'(mhold[i]));
            chk($sformatf("u%0d.data_ready", i), int'(ready_w[i]),
                int'(rst_n && (!ebusy || t[i] == fl - 1)));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #5;
   endtask

   task automatic chk_zero(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s u%0d ready", tag, i), int'(ready_w[i]), 0);
         chk($sformatf("%s u%0d hold", tag, i), int'(hold_w[i]), 0);
         chk($sformatf("%s u%0d bit_n", tag, i), int'(bitn_w[i]), 0);
         chk($sformatf("%s u%0d strobe", tag, i), int'(strobe_w[i]), 0);
         chk($sformatf("%s u%0d busy", tag, i), int'(busy_w[i]), 0);
         chk($sformatf("%s u%0d frame_done", tag, i), int'(fd_w[i]), 0);
      end
   endtask

   initial begin : stim
      logic [7:0] sel;
      logic [7:0] hb;
      int n;

      // Reset held 3 clocks with a valid byte pending.
      repeat (3) begin
         tick();
         chk_zero("reset");
      end
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("release u%0d ready", i), int'(ready_w[i]), 1);
         chk($sformatf("release u%0d busy", i), int'(busy_w[i]), 0);
      end
      tick();
      data_valid = 1'b0;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("first u%0d busy", i), int'(busy_w[i]), 1);
         chk($sformatf("first u%0d hold", i), int'(hold_w[i]), 8'hFF);
      end
      repeat (40) tick();

      // Single byte, LSB first (u0); BIT_CYCLES=1 boundary on u3.
      data_in = 8'hA5;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < 4; c++) begin
            n = k * 4 + c;
            chk("lsb bit_n", int'(bitn_w[0]), k);
            chk("lsb strobe", int'(strobe_w[0]), int'(c == 0));
            chk("lsb hold", int'(hold_w[0]), 8'hA5);
            chk("lsb busy", int'(busy_w[0]), 1);
            if (n < 8) begin
               chk("bc1 bit_n", int'(bitn_w[3]), n);
               chk("bc1 strobe", int'(strobe_w[3]), 1);
            end else if (n == 8) begin
               chk("bc1 frame_done", int'(fd_w[3]), 1);
               chk("bc1 busy", int'(busy_w[3]), 0);
            end
            tick();
         end
      end
      chk("lsb frame_done", int'(fd_w[0]), 1);
      chk("lsb busy end", int'(busy_w[0]), 0);
      chk("lsb bit_n end", int'(bitn_w[0]), 7);

      // MSB first (u1): selected bits of 8'h3C in send order.
      data_in = 8'h3C;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      sel = 8'h00;
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < 4; c++) begin
            chk("msb bit_n", int'(bitn_w[1]), 7 - k);
            if (c == 0) begin
               hb  = hold_w[1];
               sel = {sel[6:0], hb[bitn_w[1]]};
            end
            tick();
         end
      end
      chk("msb selected bits", int'(sel), 8'b0011_1100);
      chk("msb frame_done", int'(fd_w[1]), 1);

      // Back-to-back on u2 (BIT_CYCLES=2).
      data_in = 8'h01;
      data_valid = 1'b1;
      tick();
      data_in = 8'h80;
      repeat (15) tick();
      chk("b2b ready last clock", int'(ready_w[2]), 1);
      chk("b2b bit_n before", int'(bitn_w[2]), 7);
      tick();
      data_valid = 1'b0;
      chk("b2b frame_done", int'(fd_w[2]), 1);
      chk("b2b strobe", int'(strobe_w[2]), 1);
      chk("b2b bit_n reload", int'(bitn_w[2]), 0);
      chk("b2b hold", int'(hold_w[2]), 8'h80);
      chk("b2b busy", int'(busy_w[2]), 1);
      repeat (16) tick();
      chk("b2b frame_done 2", int'(fd_w[2]), 1);
      chk("b2b busy end", int'(busy_w[2]), 0);
      chk("b2b hold end", int'(hold_w[2]), 8'h80);

      // Busy-time stimulus on u0.
      data_in = 8'h5A;
      data_valid = 1'b1;
      tick();
      for (int k = 0; k < 20; k++) begin
         data_valid = k[0];
         data_in = 8'(k * 37 + 1);
         chk("busy ready", int'(ready_w[0]), 0);
         chk("busy hold", int'(hold_w[0]), 8'h5A);
         tick();
      end
      data_valid = 1'b0;
      repeat (12) tick();
      chk("busy frame_done", int'(fd_w[0]), 1);
      chk("busy no extra frame", int'(busy_w[0]), 0);
      chk("busy hold end", int'(hold_w[0]), 8'h5A);
      repeat (20) tick();

      // Reset mid-frame while u0 shows bit 3.
      data_in = 8'hC3;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      repeat (12) tick();
      chk("midrst bit_n before", int'(bitn_w[0]), 3);
      rst_n = 1'b0;
      tick();
      chk_zero("midrst");
      rst_n = 1'b1;
      #1;
      chk("midrst ready after", int'(ready_w[0]), 1);
      data_in = 8'h99;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("midrst new hold", int'(hold_w[0]), 8'h99);
      chk("midrst new busy", int'(busy_w[0]), 1);
      chk("midrst new bit_n", int'(bitn_w[0]), 0);
      chk("midrst new strobe", int'(strobe_w[0]), 1);
      repeat (40) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/byte_bit_sequencer.md
# byte_bit_sequencer

Parallel-to-serial sequencer that sits directly upstream of the decoder's bit-select stage. It accepts one byte at a time over a valid/ready handshake and holds it on `hold_byte`. It then steps `bit_n` through all eight bit positions, holding each position for a programmable number of clocks, so that the downstream bit-select mux produces a serial bit stream. Frame-level strobes mark bit boundaries and byte completion for the consuming logic.

## Interface
- `BIT_CYCLES`, default 4: clocks each bit position is held. Legal range 1..255.
- `MSB_FIRST`, default 0:
  - 0 sends bit_n 0→7.
  - 1 sends bit_n 7→0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `data_in`  in  8  byte to serialize; sampled only on handshake.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  block can accept a byte this cycle. Combinational from state/counters, forced 0 while `rst_n`=0.
- `hold_byte`  out  8  registered copy of the accepted byte, fed to the bit-select stage's data input.
- `bit_n`  out  3  current bit index, fed to the bit-select stage.
- `bit_strobe`  out  1  one-cycle pulse on the first clock of each bit period.
- `busy`  out  1  high while a byte is being sequenced.
- `frame_done`  out  1  one-cycle pulse after the last bit period of a byte ends.

## Operation
- **Reset values:** `hold_byte`=0, `bit_n`=0, `bit_strobe`=0, `busy`=0, `frame_done`=0, state IDLE, internal counters 0.
- **States:** IDLE, SEND.
- **Handshake:** a byte is accepted at a rising edge where `data_valid`=1 and `data_ready`=1.
  - On accept: `hold_byte` ← `data_in`; `bit_n` ← first index (0 or 7 per `MSB_FIRST`); cycle counter ← 0; bit counter ← 0; state ← SEND.
- **IDLE:** `data_ready`=1. `data_in` is ignored unless `data_valid`=1.
- **SEND:**
  - Each clock, the cycle counter increments.
  - When cycle counter = BIT_CYCLES−1 and bit counter < 7: cycle counter ← 0, bit counter +1, and `bit_n` steps by ±1 per `MSB_FIRST`.
  - When cycle counter = BIT_CYCLES−1 and bit counter = 7, the frame ends. If a handshake occurs in that cycle, the block reloads immediately (back-to-back, no gap). Otherwise state ← IDLE and `bit_n` holds its last value.
- **`data_ready` in SEND:** high only during the last clock of bit 7; low otherwise. Changes on `data_in`/`data_valid` while busy have no effect.
- **`bit_strobe`:** registered; 1 in the first clock of every bit period, including the first bit after accept.
- **`busy`:** 1 exactly while in SEND.
- **`frame_done`:** registered; 1 for the single clock following the edge that ends bit 7. This holds whether the block goes to IDLE or reloads.
- **`hold_byte`:** stable for the whole frame; changes only on accept.
- **Widths:**
  - Cycle counter is ceil(log2(BIT_CYCLES)) bits, minimum 1.
  - Bit counter is 3 bits.
  - `bit_n` never wraps mid-frame.
- **Reset mid-frame:** any cycle with `rst_n`=0 returns every register to its reset value at that edge. The partial frame is discarded and no `frame_done` is issued.

## Timing
- Accept at edge E0. Bit k (k=0..7 in send order) is presented on `bit_n` from edge E0+k·BIT_CYCLES to edge E0+(k+1)·BIT_CYCLES.
- Handshake-to-first-bit latency: 1 edge. Frame length: 8·BIT_CYCLES clocks.
- `frame_done` is high in the clock after edge E0+8·BIT_CYCLES.
- Sustained throughput with continuous `data_valid`: one byte per 8·BIT_CYCLES clocks, with no idle clock between frames.
- `BIT_CYCLES`=1: `bit_n` changes every clock and `bit_strobe` stays high for the entire frame.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 clocks while `data_valid`=1, `data_in`=8'hFF.
  - During reset: all outputs are 0, including `data_ready`.
  - After release: `data_ready`=1 and nothing is accepted until the first edge with `rst_n`=1.
- **Single byte, LSB first:** BIT_CYCLES=4, MSB_FIRST=0, send 8'hA5.
  - `hold_byte`=8'hA5 for 32 clocks.
  - `bit_n` = 0,1,…,7, each held 4 clocks.
  - 8 `bit_strobe` pulses, 4 clocks apart.
  - `frame_done` one clock after the 32nd clock; `busy` falls at the same point.
- **MSB first:** MSB_FIRST=1, send 8'h3C.
  - `bit_n` sequence is 7→0.
  - Downstream selected bits read 0,0,1,1,1,1,0,0.
- **Back-to-back:** BIT_CYCLES=2, `data_valid` held high with 8'h01 then 8'h80.
  - Second byte accepted in the last clock of bit 7 of the first.
  - `bit_n` jumps 7→0 with no gap; `frame_done` and `bit_strobe` coincide.
  - Total 32 clocks for both bytes.
- **Busy-time stimulus:** toggle `data_valid` and `data_in` mid-frame.
  - `data_ready`=0 throughout.
  - `hold_byte` unchanged.
  - No extra frame is started.
- **Reset mid-frame:** assert `rst_n`=0 while `bit_n`=3.
  - Next edge: state IDLE, outputs at reset values, no `frame_done`.
  - A new byte is accepted normally after release.
